// File: rtl/stage_if_prefetch.sv
// Decoupled instruction-fetch stage with a credit-limited prefetch FIFO, in-order IMEM responses and redirect flush.
// Optional STAGE_IF_MISALIGN_CHK_EN: a misaligned redirect raises fetch_misalign and halts issue until an aligned redirect.
module stage_if_prefetch #(
   parameter int unsigned          PC_WIDTH   = 32,
   parameter int unsigned          INST_WIDTH = 32,
   parameter int unsigned          FIFO_DEPTH = 4,
   parameter logic [PC_WIDTH-1:0]  RESET_PC   = '0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [PC_WIDTH-1:0]   pc_imm,
   input  logic                  pc_sel,
   input  logic                  IF_flush,
   input  logic                  IF_ID_write,
   output logic                  imem_req_valid,
   input  logic                  imem_req_ready,
   output logic [PC_WIDTH-1:0]   imem_req_addr,
   input  logic                  imem_rsp_valid,
   input  logic [INST_WIDTH-1:0] imem_rsp_data,
   output logic                  inst_valid,
   output logic [PC_WIDTH-1:0]   pc,
   output logic [PC_WIDTH-1:0]   pc_next,
   output logic [INST_WIDTH-1:0] inst,
   output logic                  fetch_misalign
);

   localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned SUM_W = CNT_W + 1;

   logic [PC_WIDTH-1:0]   fetch_pc_q, fetch_pc_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rq_rd_q, rq_rd_d, rq_wr_q, rq_wr_d;
   logic [CNT_W-1:0]      count_q, count_d, out_q, out_d, drop_q, drop_d;
   logic [SUM_W-1:0]      drop_sum;

   logic [PC_WIDTH-1:0]   fifo_pc   [FIFO_DEPTH];
   logic [INST_WIDTH-1:0] fifo_inst [FIFO_DEPTH];
   logic [PC_WIDTH-1:0]   rq_pc     [FIFO_DEPTH];

   logic                  halted, credit_ok, issue, rsp_drop, rsp_take, push, pop, head_valid;
   logic [PC_WIDTH-1:0]   redirect_pc;

`ifdef STAGE_IF_MISALIGN_CHK_EN
   logic misalign_q, misalign_d;
   assign halted         = misalign_q;
   assign redirect_pc    = pc_imm;
   assign fetch_misalign = misalign_q;
`else
   assign halted         = 1'b0;
   assign redirect_pc    = pc_imm & ~PC_WIDTH'(3);
   assign fetch_misalign = 1'b0;
`endif

   // Issue gating: outstanding requests plus buffered entries never exceed the FIFO depth.
   assign credit_ok      = (SUM_W'(count_q) + SUM_W'(out_q)) < SUM_W'(FIFO_DEPTH);
   assign imem_req_valid = !reset && !pc_sel && !halted && credit_ok;
   assign imem_req_addr  = fetch_pc_q;
   assign issue          = imem_req_valid && imem_req_ready;

   assign rsp_drop   = imem_rsp_valid && (drop_q != '0);
   assign rsp_take   = imem_rsp_valid && (drop_q == '0) && (out_q != '0);
   assign push       = rsp_take && !pc_sel;
   assign head_valid = (count_q != '0);
   assign pop        = head_valid && (IF_ID_write || IF_flush);

   assign inst_valid = head_valid && !IF_flush;
   assign pc         = fifo_pc[rd_ptr_q];
   assign inst       = fifo_inst[rd_ptr_q];
   assign pc_next    = pc + PC_WIDTH'(4);

   assign drop_sum = SUM_W'(drop_q) + SUM_W'(out_q) - SUM_W'(rsp_drop || rsp_take);

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      rq_rd_d    = rq_rd_q;
      rq_wr_d    = rq_wr_q;
      count_d    = count_q;
      out_d      = out_q;
      drop_d     = drop_q;
`ifdef STAGE_IF_MISALIGN_CHK_EN
      misalign_d = misalign_q;
`endif
      if (pc_sel) begin
         // Redirect: everything still owed by IMEM becomes a response to discard.
         fetch_pc_d = redirect_pc;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         rq_rd_d    = '0;
         rq_wr_d    = '0;
         count_d    = '0;
         out_d      = '0;
         drop_d     = CNT_W'(drop_sum);
`ifdef STAGE_IF_MISALIGN_CHK_EN
         misalign_d = |pc_imm[1:0];
`endif
      end else begin
         if (issue) begin
            fetch_pc_d = fetch_pc_q + PC_WIDTH'(4);
            rq_wr_d    = rq_wr_q + PTR_W'(1);
         end
         if (rsp_drop) drop_d = drop_q - CNT_W'(1);
         if (rsp_take) rq_rd_d = rq_rd_q + PTR_W'(1);
         if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
         out_d   = out_q + CNT_W'(issue) - CNT_W'(rsp_take);
         count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_pc_q <= RESET_PC;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         rq_rd_q    <= '0;
         rq_wr_q    <= '0;
         count_q    <= '0;
         out_q      <= '0;
         drop_q     <= '0;
`ifdef STAGE_IF_MISALIGN_CHK_EN
         misalign_q <= 1'b0;
`endif
      end else begin
         fetch_pc_q <= fetch_pc_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         rq_rd_q    <= rq_rd_d;
         rq_wr_q    <= rq_wr_d;
         count_q    <= count_d;
         out_q      <= out_d;
         drop_q     <= drop_d;
`ifdef STAGE_IF_MISALIGN_CHK_EN
         misalign_q <= misalign_d;
`endif
      end
   end

   // Payload storage needs no reset; validity comes from the counters.
   always_ff @(posedge clk) begin
      if (issue) rq_pc[rq_wr_q] <= fetch_pc_q;
      if (push) begin
         fifo_pc[wr_ptr_q]   <= rq_pc[rq_rd_q];
         fifo_inst[wr_ptr_q] <= imem_rsp_data;
      end
   end

endmodule

// File: tb/tb_stage_if_prefetch.sv
// Directed bench for stage_if_prefetch: vector table for streaming/stall/flush, plus redirect, wrap and misalign sequences.
module tb_stage_if_prefetch;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] pc_imm;
   logic        pc_sel, IF_flush, IF_ID_write;
   logic        imem_req_valid, imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        inst_valid;
   logic [31:0] pc, pc_next, inst;
   logic        fetch_misalign;

   stage_if_prefetch dut (
      .clk(clk), .reset(reset), .pc_imm(pc_imm), .pc_sel(pc_sel), .IF_flush(IF_flush),
      .IF_ID_write(IF_ID_write), .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
      .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .inst_valid(inst_valid), .pc(pc), .pc_next(pc_next), .inst(inst), .fetch_misalign(fetch_misalign)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   // In-order IMEM model: fixed latency, instruction word = ~address.
   logic [31:0] q_addr[$];
   int          q_due[$];
   int          cyc;
   int          lat;

   typedef struct {
      logic        wr;
      logic        fl;
      logic        exp_valid;
      logic [31:0] exp_pc;
      logic        exp_reqv;
      logic [31:0] exp_addr;
   } vec_t;

   vec_t vec[26];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s (cycle %0d): got %h, expected %h", name, cyc, act, exp);
      end
   endtask

   task automatic tick();
      logic        taken;
      logic [31:0] tmp_a;
      int          tmp_d;
      @(negedge clk);
      if (imem_req_valid && imem_req_ready) begin
         q_addr.push_back(imem_req_addr);
         q_due.push_back(cyc + lat);
      end
      taken = imem_rsp_valid;
      @(posedge clk);
      #1;
      cyc++;
      if (taken) begin
         tmp_a = q_addr.pop_front();
         tmp_d = q_due.pop_front();
      end
      if (q_addr.size() > 0 && q_due[0] <= cyc) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = ~q_addr[0];
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = '0;
      end
   endtask

   task automatic do_reset(input int latency);
      reset          = 1'b1;
      pc_imm         = '0;
      pc_sel         = 1'b0;
      IF_flush       = 1'b0;
      IF_ID_write    = 1'b1;
      imem_req_ready = 1'b1;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      q_addr.delete();
      q_due.delete();
      @(posedge clk);
      #1;
      chk("reset inst_valid", 32'(inst_valid), 32'd0);
      chk("reset req_valid", 32'(imem_req_valid), 32'd0);
      chk("reset misalign", 32'(fetch_misalign), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      cyc   = 0;
      lat   = latency;
   endtask

   task automatic wait_valid(input int budget, output int at);
      at = -1;
      for (int i = 0; i < budget; i++) begin
         #1;
         if (inst_valid) begin
            at = cyc;
            return;
         end
         tick();
      end
   endtask

   initial begin
      int at;

      // Streaming from reset, flush of head 0x8 at cycle 4, 10-cycle stall, release.
      for (int k = 0; k < 26; k++) begin
         vec[k].wr        = !((k >= 8 && k <= 17) || k == 4);
         vec[k].fl        = (k == 4);
         vec[k].exp_valid = (k >= 2) && (k != 4);
         vec[k].exp_pc    = (k <= 8)  ? 32'(4 * (k - 2)) :
                            (k <= 18) ? 32'h18 : 32'(32'h18 + 4 * (k - 18));
         vec[k].exp_reqv  = !(k >= 10 && k <= 18);
         vec[k].exp_addr  = (k <= 9)  ? 32'(4 * k) :
                            (k <= 18) ? 32'h28 : 32'(32'h28 + 4 * (k - 19));
      end

      do_reset(1);
      for (int k = 0; k < 26; k++) begin
         IF_ID_write = vec[k].wr;
         IF_flush    = vec[k].fl;
         #1;
         chk($sformatf("vec%0d inst_valid", k), 32'(inst_valid), 32'(vec[k].exp_valid));
         chk($sformatf("vec%0d req_valid", k), 32'(imem_req_valid), 32'(vec[k].exp_reqv));
         if (vec[k].exp_valid) begin
            chk($sformatf("vec%0d pc", k), pc, vec[k].exp_pc);
            chk($sformatf("vec%0d pc_next", k), pc_next, vec[k].exp_pc + 32'd4);
            chk($sformatf("vec%0d inst", k), inst, ~vec[k].exp_pc);
         end
         if (vec[k].exp_reqv)
            chk($sformatf("vec%0d req_addr", k), imem_req_addr, vec[k].exp_addr);
         tick();
      end
      IF_flush    = 1'b0;
      IF_ID_write = 1'b1;

      // Redirect with three requests in flight at latency 3.
      do_reset(3);
      tick();
      tick();
      tick();
      pc_sel = 1'b1;
      pc_imm = 32'h100;
      #1;
      chk("redirect cycle req_valid", 32'(imem_req_valid), 32'd0);
      tick();
      pc_sel = 1'b0;
      #1;
      chk("post-redirect req_addr", imem_req_addr, 32'h100);
      chk("post-redirect req_valid", 32'(imem_req_valid), 32'd1);
      wait_valid(12, at);
      chk("redirect first valid cycle", 32'(at), 32'd8);
      chk("redirect first pc", pc, 32'h100);
      chk("redirect first inst", inst, ~32'h100);

      // Fetch PC wrap at the top of the address space.
      do_reset(1);
      pc_sel = 1'b1;
      pc_imm = 32'hFFFF_FFFC;
      tick();
      pc_sel = 1'b0;
      #1;
      chk("wrap req_addr", imem_req_addr, 32'hFFFF_FFFC);
      tick();
      #1;
      chk("wrap next req_addr", imem_req_addr, 32'h0);
      wait_valid(8, at);
      chk("wrap valid cycle", 32'(at), 32'd3);
      chk("wrap pc", pc, 32'hFFFF_FFFC);
      chk("wrap pc_next", pc_next, 32'h0);

      // Misaligned redirect.
      do_reset(1);
      pc_sel = 1'b1;
      pc_imm = 32'h102;
      tick();
      pc_sel = 1'b0;
`ifdef STAGE_IF_MISALIGN_CHK_EN
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("misalign flag", 32'(fetch_misalign), 32'd1);
         chk("misalign halted req", 32'(imem_req_valid), 32'd0);
         chk("misalign no inst", 32'(inst_valid), 32'd0);
         tick();
      end
      pc_sel = 1'b1;
      pc_imm = 32'h200;
      tick();
      pc_sel = 1'b0;
      #1;
      chk("realign flag", 32'(fetch_misalign), 32'd0);
      chk("realign req_addr", imem_req_addr, 32'h200);
      chk("realign req_valid", 32'(imem_req_valid), 32'd1);
      wait_valid(8, at);
      chk("realign valid cycle", 32'(at), 32'd7);
      chk("realign pc", pc, 32'h200);
`else
      #1;
      chk("misalign tied low", 32'(fetch_misalign), 32'd0);
      chk("aligned req_addr", imem_req_addr, 32'h100);
      chk("aligned req_valid", 32'(imem_req_valid), 32'd1);
      wait_valid(8, at);
      chk("aligned valid cycle", 32'(at), 32'd3);
      chk("aligned pc", pc, 32'h100);
`endif

      // Reset in the middle of streaming.
      tick();
      tick();
      do_reset(1);
      #1;
      chk("post-reset req_addr", imem_req_addr, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
